// File: rtl/mux_scan_n.sv
// N-channel, W-bit registered multiplexer with manual select and an automatic
// scan sequencer; the output is a registered valid/ready stream.
module mux_scan_n #(
    parameter int N_CH    = 10,
    parameter int W       = 1,
    parameter int SEL_W   = 4,
    parameter int DWELL_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_CH*W-1:0]   in_data,
    input  logic                mode,
    input  logic [SEL_W-1:0]    sel,
    input  logic [DWELL_W-1:0]  dwell,
    input  logic                start,
    output logic [W-1:0]        out_data,
    output logic [SEL_W-1:0]    out_ch,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                sel_err,
    output logic                busy,
    output logic                done
);

    typedef enum logic [1:0] {IDLE, SCAN, WAIT} state_t;

    state_t               state, state_next;
    logic [SEL_W-1:0]     ch, ch_next;
    logic [DWELL_W-1:0]   dwell_lat, dwell_lat_next;
    logic [DWELL_W-1:0]   dwell_cnt, dwell_cnt_next;
    logic [W-1:0]         out_data_next;
    logic [SEL_W-1:0]     out_ch_next;
    logic                 out_valid_next, sel_err_next, done_next;
    logic                 slot_free;

    // Out-of-range indices select zero rather than an undefined slice.
    function automatic logic [W-1:0] pick(input logic [N_CH*W-1:0] bus,
                                          input logic [SEL_W-1:0]  idx);
        pick = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (idx == SEL_W'(k)) pick = bus[k*W +: W];
        end
    endfunction

    function automatic logic in_range(input logic [SEL_W-1:0] idx);
        in_range = ({1'b0, idx} < (SEL_W+1)'(N_CH));
    endfunction

    assign slot_free = !out_valid || out_ready;
    assign busy      = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            ch        <= '0;
            dwell_lat <= '0;
            dwell_cnt <= '0;
            out_data  <= '0;
            out_ch    <= '0;
            out_valid <= 1'b0;
            sel_err   <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_next;
            ch        <= ch_next;
            dwell_lat <= dwell_lat_next;
            dwell_cnt <= dwell_cnt_next;
            out_data  <= out_data_next;
            out_ch    <= out_ch_next;
            out_valid <= out_valid_next;
            sel_err   <= sel_err_next;
            done      <= done_next;
        end
    end

    always_comb begin
        state_next     = state;
        ch_next        = ch;
        dwell_lat_next = dwell_lat;
        dwell_cnt_next = dwell_cnt;
        out_data_next  = out_data;
        out_ch_next    = out_ch;
        out_valid_next = out_valid;
        sel_err_next   = sel_err;
        done_next      = 1'b0;

        // An accepted sample retires unless a new load replaces it below.
        if (out_valid && out_ready) out_valid_next = 1'b0;

        case (state)
            IDLE: begin
                if (!mode) begin
                    if (slot_free) begin
                        out_data_next  = pick(in_data, sel);
                        out_ch_next    = sel;
                        sel_err_next   = !in_range(sel);
                        out_valid_next = 1'b1;
                    end
                end else if (start) begin
                    dwell_lat_next = dwell;
                    dwell_cnt_next = '0;
                    ch_next        = '0;
                    state_next     = SCAN;
                end
            end
            SCAN: begin
                if (dwell_cnt != '0) begin
                    dwell_cnt_next = dwell_cnt - DWELL_W'(1);
                end else if (slot_free) begin
                    out_data_next  = pick(in_data, ch);
                    out_ch_next    = ch;
                    sel_err_next   = 1'b0;
                    out_valid_next = 1'b1;
                    dwell_cnt_next = dwell_lat;
                    if (ch == SEL_W'(N_CH-1)) state_next = WAIT;
                    else                      ch_next    = ch + SEL_W'(1);
                end
            end
            WAIT: begin
                // The final sample is always valid here; completion waits for its handshake.
                if (out_ready) begin
                    out_valid_next = 1'b0;
                    done_next      = 1'b1;
                    ch_next        = '0;
                    dwell_cnt_next = '0;
                    state_next     = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mux_scan_n.sv
// Self-checking bench for mux_scan_n: manual-select vector table, directed scan
// sequences, and randomized scans checked against a channel-order scoreboard.
module tb_mux_scan_n;
    localparam int N_CH    = 10;
    localparam int W       = 8;
    localparam int SEL_W   = 4;
    localparam int DWELL_W = 8;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [N_CH*W-1:0]   in_data;
    logic                mode;
    logic [SEL_W-1:0]    sel;
    logic [DWELL_W-1:0]  dwell;
    logic                start;
    logic [W-1:0]        out_data;
    logic [SEL_W-1:0]    out_ch;
    logic                out_valid;
    logic                out_ready;
    logic                sel_err;
    logic                busy;
    logic                done;

    mux_scan_n #(.N_CH(N_CH), .W(W), .SEL_W(SEL_W), .DWELL_W(DWELL_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .mode(mode), .sel(sel),
        .dwell(dwell), .start(start), .out_data(out_data), .out_ch(out_ch),
        .out_valid(out_valid), .out_ready(out_ready), .sel_err(sel_err),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    logic [W-1:0] chan [N_CH];

    typedef struct {
        logic [SEL_W-1:0] sel;
        logic [W-1:0]     exp_data;
        logic [SEL_W-1:0] exp_ch;
        logic             exp_err;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic load_pattern(input bit rnd);
        for (int k = 0; k < N_CH; k++) begin
            chan[k] = rnd ? W'($urandom_range(0, 255)) : W'(16*k + 1);
            in_data[k*W +: W] = chan[k];
        end
    endtask

    // policy 0: always ready; 1: hold ready low 5 cycles while ch4 is presented; 2: random ready
    task automatic run_scan(input int dw, input int policy, input bit noise);
        int  exp_idx   = 0;
        int  last_load = -1;
        int  hold_cnt  = 0;
        int  budget    = 0;
        bit  finished  = 0;
        bit  prev_hold = 0, prev_valid = 0, prev_hs = 0;
        bit  hs, new_load;
        logic [W-1:0]     prev_data = '0;
        logic [SEL_W-1:0] prev_ch   = '0;
        mode  = 1'b1;
        dwell = DWELL_W'(dw);
        start = 1'b1;
        step();
        start = 1'b0;
        while (!finished && budget < 400) begin
            if (prev_hold) begin
                chk("hold_valid", out_valid, 1'b1);
                chk("hold_data", out_data, prev_data);
                chk("hold_ch", out_ch, prev_ch);
            end
            new_load = out_valid && (!prev_valid || prev_hs);
            if (new_load) begin
                if (last_load >= 0) chk("load_spacing", (cyc - last_load) >= dw + 1, 1'b1);
                last_load = cyc;
            end
            chk("scan_done_low", done, 1'b0);
            chk("scan_busy", busy, 1'b1);
            case (policy)
                1: begin
                    if (out_valid && out_ch == 4'd4 && hold_cnt < 5) begin
                        out_ready = 1'b0;
                        hold_cnt++;
                    end else out_ready = 1'b1;
                end
                2:       out_ready = ($urandom_range(0, 9) < 7);
                default: out_ready = 1'b1;
            endcase
            hs = out_valid && out_ready;
            if (hs) begin
                chk("scan_ch", out_ch, exp_idx);
                chk("scan_data", out_data, (exp_idx < N_CH) ? chan[exp_idx] : 'x);
                exp_idx++;
            end
            if (hs && exp_idx == N_CH) begin
                mode  = 1'b1;
                start = 1'b0;
                step();
                chk("done_pulse", done, 1'b1);
                chk("done_busy", busy, 1'b0);
                chk("done_valid", out_valid, 1'b0);
                step();
                chk("done_single", done, 1'b0);
                finished = 1;
            end else begin
                if (noise) begin
                    mode  = 1'($urandom_range(0, 1));
                    sel   = SEL_W'($urandom_range(0, 15));
                    start = 1'($urandom_range(0, 1));
                end
                prev_hold  = out_valid && !out_ready;
                prev_valid = out_valid;
                prev_hs    = hs;
                prev_data  = out_data;
                prev_ch    = out_ch;
                step();
                budget++;
            end
        end
        if (policy == 1) chk("bp_hold_seen", hold_cnt, 5);
        if (!finished) chk("scan_timeout", 1'b0, 1'b1);
        start = 1'b0;
        mode  = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [12];
        bit   found;
        rst_n = 1'b0; start = 1'b1; mode = 1'b1; sel = '0; dwell = '0; out_ready = 1'b1;
        load_pattern(0);

        // Reset with start asserted
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_valid", out_valid, 1'b0);
            chk("rst_data", out_data, 8'h00);
            chk("rst_busy", busy, 1'b0);
            chk("rst_done", done, 1'b0);
        end
        rst_n = 1'b1; start = 1'b0;
        step(); step();
        chk("post_rst_busy", busy, 1'b0);
        chk("post_rst_valid", out_valid, 1'b0);

        // Manual-select table
        tbl[0] = '{4'd3,  8'h31, 4'd3,  1'b0};
        tbl[1] = '{4'd9,  8'h91, 4'd9,  1'b0};
        tbl[2] = '{4'd12, 8'h00, 4'd12, 1'b1};
        tbl[3] = '{4'd0,  8'h01, 4'd0,  1'b0};
        tbl[4] = '{4'd15, 8'h00, 4'd15, 1'b1};
        tbl[5] = '{4'd10, 8'h00, 4'd10, 1'b1};
        for (int i = 6; i < 12; i++) begin
            int s = $urandom_range(0, 15);
            tbl[i].sel      = SEL_W'(s);
            tbl[i].exp_data = (s < N_CH) ? W'(16*s + 1) : 8'h00;
            tbl[i].exp_ch   = SEL_W'(s);
            tbl[i].exp_err  = (s >= N_CH);
        end
        mode = 1'b0;
        for (int i = 0; i < 12; i++) begin
            sel = tbl[i].sel;
            step();
            chk("man_data", out_data, tbl[i].exp_data);
            chk("man_ch", out_ch, tbl[i].exp_ch);
            chk("man_err", sel_err, tbl[i].exp_err);
            chk("man_valid", out_valid, 1'b1);
        end
        mode = 1'b1;
        step();
        chk("scan_mode_idle_valid", out_valid, 1'b0);
        step();
        chk("scan_mode_no_load", out_valid, 1'b0);

        // Full scan, no dwell, exact timing
        dwell = '0; start = 1'b1;
        step();
        start = 1'b0;
        chk("fs_start_busy", busy, 1'b1);
        chk("fs_start_noload", out_valid, 1'b0);
        for (int k = 0; k < N_CH; k++) begin
            step();
            chk("fs_ch", out_ch, k);
            chk("fs_data", out_data, 16*k + 1);
            chk("fs_valid", out_valid, 1'b1);
            chk("fs_done_low", done, 1'b0);
        end
        step();
        chk("fs_done", done, 1'b1);
        chk("fs_busy_low", busy, 1'b0);
        chk("fs_valid_low", out_valid, 1'b0);
        step();
        chk("fs_done_once", done, 1'b0);

        // Backpressure with dwell 3
        run_scan(3, 1, 0);

        // Reset mid-scan
        dwell = 8'd2; mode = 1'b1; start = 1'b1; out_ready = 1'b1;
        step();
        start = 1'b0;
        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            if (out_valid && out_ch == 4'd6) found = 1;
            else step();
        end
        chk("ms_reach_ch6", found, 1'b1);
        rst_n = 1'b0;
        step();
        chk("ms_valid", out_valid, 1'b0);
        chk("ms_busy", busy, 1'b0);
        chk("ms_done", done, 1'b0);
        rst_n = 1'b1;
        step();
        chk("ms_no_resume", out_valid, 1'b0);
        chk("ms_no_done", done, 1'b0);
        run_scan(0, 0, 0);

        // Randomized scans with ignored-input noise
        for (int n = 0; n < 12; n++) begin
            load_pattern(1);
            run_scan($urandom_range(0, 4), 2, 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end
endmodule

// File: doc/mux_scan_n.md
Name: mux_scan_n

Overview:
- Parametrised N-channel, W-bit registered multiplexer. Generalises the fixed 10:1 single-bit selector.
- Two modes: manual select, and an automatic scan sequencer that sweeps all channels once per start, with a programmable dwell between samples.
- Output is a registered valid/ready stream, so the block can feed a serialiser or capture stage that applies backpressure.

Parameters:
- N_CH, 10, number of input channels (2..16).
- W, 1, bits per channel.
- SEL_W, 4, select/channel-index width; must satisfy 2**SEL_W >= N_CH.
- DWELL_W, 8, dwell counter width.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- in_data  in  N_CH*W  channel k occupies bits [k*W +: W].
- mode  in  1  0 = manual, 1 = scan; sampled only while busy=0.
- sel  in  SEL_W  manual channel select.
- dwell  in  DWELL_W  idle cycles between scan loads; sampled on start.
- start  in  1  single-cycle pulse; starts a scan when mode=1 and busy=0.
- out_data  out  W  registered selected data.
- out_ch  out  SEL_W  channel index of out_data.
- out_valid  out  1  out_data/out_ch valid.
- out_ready  in  1  downstream accept.
- sel_err  out  1  current output came from an out-of-range sel.
- busy  out  1  scan in progress.
- done  out  1  one-cycle pulse at scan completion.

Behaviour:
- Reset (rst_n=0 at a clk edge): out_data=0, out_ch=0, out_valid=0, sel_err=0, busy=0, done=0, state=IDLE, channel counter=0, dwell counter=0.
- Reset has priority over every other input. Reset mid-scan aborts the scan and discards any pending sample.
- Output slot rule: slot is free when out_valid=0 or out_ready=1. A load happens only when the slot is free.
- Backpressure: while out_valid=1 and out_ready=0, out_data, out_ch and sel_err hold stable.
- Handshake: a sample is transferred on a cycle with out_valid=1 and out_ready=1.
- FSM states: IDLE, SCAN, WAIT.
- IDLE, mode=0 (manual):
  - every cycle the slot is free, load in_data[sel], out_ch=sel, sel_err=0, out_valid=1.
  - latency is 1 clk from sel to out_data.
- IDLE, sel >= N_CH: load out_data=0, out_ch=sel, sel_err=1, out_valid=1. No X propagation.
- IDLE, mode=1: out_valid deasserts once the held sample is accepted. Nothing loads until start.
- IDLE, start=1 with mode=1:
  - latch dwell, channel counter=0, busy=1, go to SCAN.
  - start with mode=0 is ignored.
- SCAN:
  - when the slot is free, load in_data[ch], out_ch=ch, out_valid=1.
  - if ch==N_CH-1, go to WAIT_LAST (a WAIT sub-flag); else increment ch.
  - after a load, if latched dwell>0, the dwell counter blocks the next load for exactly dwell cycles.
  - dwell counting starts the cycle after the load and is independent of out_ready.
- WAIT_LAST: on handshake of the channel N_CH-1 sample:
  - done=1 for one cycle, busy=0, out_valid=0, go to IDLE.
  - done is asserted the cycle after that handshake.
- Ignored inputs while busy=1: start, mode and sel changes. The sweep always covers channels 0..N_CH-1 in order, with no skip or repeat.
- dwell=0: back-to-back loads, one per cycle while out_ready=1. The first load happens the cycle after start.
- done and the IDLE transition happen only after the final handshake, never on load.
- Channel counter wraps to 0 on return to IDLE. No sweep begins without a new start.
- Index arithmetic is unsigned, SEL_W bits. Data is muxed without modification.

Test Plan:
- Reset:
  - Stimulus: N_CH=10, W=8, in_data nonzero, rst_n=0 for 3 clk, start=1 during reset.
  - Required: out_valid=0, out_data=0, busy=0, done=0 throughout. No scan begins after release.
- Manual mode:
  - Stimulus: channel k data = 16k+1, out_ready=1, mode=0, sel=3, then sel=9.
  - Required: out_data=0x31 with out_ch=3 one cycle after sel=3; then out_data=0x91 with out_ch=9.
- Out-of-range select:
  - Stimulus: mode=0, sel=12.
  - Required: next cycle out_data=0x00, out_ch=12, sel_err=1, out_valid=1. Then sel=0 gives out_data=0x01, sel_err=0.
- Full scan, no dwell:
  - Stimulus: mode=1, dwell=0, out_ready=1, start pulse.
  - Required: out_ch 0..9 on 10 consecutive cycles with out_data 0x01..0x91; done pulses once, one cycle after the ch9 handshake; busy low the same cycle.
- Backpressure plus dwell:
  - Stimulus: dwell=3; out_ready=0 for 5 cycles while out_ch=4.
  - Required: out_data held at 0x41; ch5 is not loaded until ready returns; consecutive loads are at least 4 cycles apart; all 10 channels delivered in order exactly once.
- Reset mid-scan:
  - Stimulus: during a scan with dwell=2, rst_n=0 while out_ch=6; then a new start.
  - Required: the following cycle out_valid=0 and busy=0 with no done pulse; the new start begins again at ch0.
